// File: rtl/seq_sub.sv
// seq_sub: chunk-serial unsigned subtractor, diff = a - b.
// Each RUN cycle handles one CHUNK-wide slice, least significant first,
// and hands the borrow on to the next slice. Operands and result are
// exchanged through valid/ready handshakes.
module seq_sub #(
    parameter int DATAWIDTH = 16,
    parameter int CHUNK     = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] diff,
    output logic                 borrow
);

    localparam int NCHUNK = DATAWIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [DATAWIDTH-1:0]   a_q, a_d;
    logic [DATAWIDTH-1:0]   b_q, b_d;
    logic [DATAWIDTH-1:0]   work_q, work_d;
    logic                   bi_q, bi_d;
    logic [DATAWIDTH-1:0]   diff_q, diff_d;
    logic                   borrow_q, borrow_d;
    logic [CHUNK:0]         chunk_sub;

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, step through chunks, wait for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)          state_d = RUN;
            RUN:  if (idx_q == LAST_IDX) state_d = DONE;
            DONE: if (out_ready)         state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // One slice of the subtraction; the top bit of the result is the slice borrow.
    always_comb begin
        chunk_sub = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, bi_q};
    end

    // Datapath next values: operands shift down a slice per cycle and each new
    // result slice enters at the top of the working register, so after NCHUNK
    // steps slice 0 sits in the least significant position.
    always_comb begin
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        bi_d     = bi_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d    = a;
                    b_d    = b;
                    idx_d  = '0;
                    bi_d   = 1'b0;
                    work_d = '0;
                end
            end
            RUN: begin
                a_d    = a_q >> CHUNK;
                b_d    = b_q >> CHUNK;
                work_d = DATAWIDTH'({chunk_sub[CHUNK-1:0], work_q} >> CHUNK);
                bi_d   = chunk_sub[CHUNK];
                idx_d  = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    diff_d   = work_d;
                    borrow_d = chunk_sub[CHUNK];
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; the published result only moves on the final RUN step.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            bi_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            bi_q     <= bi_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Result ports.
    always_comb begin
        diff   = diff_q;
        borrow = borrow_q;
    end

endmodule

// File: doc/seq_sub.md
Name: seq_sub

Overview:
- Multi-cycle, chunk-serial subtractor: computes diff = a - b over DATAWIDTH/CHUNK cycles, passing a borrow between chunks.
- It is the inverse-operation counterpart to the datapath adder and shares its DATAWIDTH parameterisation.
- Operands and results use valid/ready handshakes, so the block sits between a producer stage and a consumer stage that may stall.
- The final borrow out is reported as an underflow flag.

Parameters:
- DATAWIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits processed per cycle; must divide DATAWIDTH evenly; NCHUNK = DATAWIDTH/CHUNK.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands.
- a  input  DATAWIDTH  minuend, unsigned.
- b  input  DATAWIDTH  subtrahend, unsigned.
- out_valid  output  1  diff and borrow are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  DATAWIDTH  a - b modulo 2^DATAWIDTH.
- borrow  output  1  1 when a < b (unsigned underflow).

Behaviour:
- States: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state.
- Reset (Rst_n low, asynchronous):
  - state=IDLE; diff=0; borrow=0; chunk index=0; working regs=0.
  - out_valid=0 and in_ready=1 immediately.
- IDLE:
  - On the edge where in_valid && in_ready: latch a and b into working regs, clear index and carry-borrow, go to RUN.
  - If in_valid is low, stay in IDLE.
- RUN, each cycle for chunk k = index:
  - {bo, d} = a[k] - b[k] - bi, computed CHUNK+1 bits wide; bi is the stored borrow (0 for k=0).
  - Write d into working result chunk k and store bo.
  - Increment the index.
- RUN exit:
  - When k == NCHUNK-1, on the same edge, load diff with the completed working result and borrow with the final bo, then go to DONE.
  - Chunk 0 is the least significant chunk.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (4 cycles at the defaults).
- DONE:
  - diff and borrow are held stable.
  - On the edge where out_valid && out_ready, go to IDLE; in_ready is high the next cycle.
  - No new operand is accepted in the same cycle as the output handshake.
  - Throughput is one result per NCHUNK+2 cycles with out_ready tied high.
- diff and borrow change only on the RUN→DONE edge and on reset. Between operations they retain the last result.
- in_valid while busy (RUN or DONE) is ignored. Operand changes after acceptance have no effect.
- out_ready in IDLE or RUN is ignored.
- Reset mid-RUN or mid-DONE aborts the operation: no result is produced, and outputs return to reset values.
- CHUNK == DATAWIDTH is legal: RUN lasts one cycle and latency is 1.
- Arithmetic is unsigned modulo 2^DATAWIDTH. For signed use, borrow is not the overflow flag; signed overflow is out of scope.

Test Plan:
- Basic subtract: a=16'h1234, b=16'h0234, out_ready=1 → out_valid high 4 cycles after accept, diff=16'h1000, borrow=0, out_valid high for exactly 1 cycle.
- Full borrow ripple: a=16'h0000, b=16'h0001 → diff=16'hFFFF, borrow=1. Then a=16'h8000, b=16'h0001 → diff=16'h7FFF, borrow=0, with the borrow propagating across all chunks.
- Backpressure: a=16'hABCD, b=16'hABCD, out_ready held low 6 cycles → diff=16'h0000, borrow=0, out_valid stays 1 with stable outputs, in_ready=0. A second in_valid pulse (a=16'h0005, b=16'h0003) during DONE is ignored; releasing out_ready returns the block to IDLE.
- Back-to-back: in_valid held high with a=16'h0010, b=16'h0001, then a=16'h0001, b=16'h0010 → results 16'h000F with borrow=0, then 16'hFFF1 with borrow=1. The second accept occurs 1 cycle after the first output handshake, giving a 6-cycle period.
- Reset mid-RUN: accept a=16'hFFFF, b=16'h0001, assert Rst_n low asynchronously 2 cycles later → diff=0, borrow=0, out_valid=0, in_ready=1 immediately. No stale result appears after Rst_n deasserts.
- Parameter sweep: CHUNK=16 and CHUNK=1 with a=16'h0003, b=16'h0005 → diff=16'hFFFE, borrow=1, with latency of 1 and 16 cycles respectively.
